atm_machine: RTL and testbench



---
 rtl/atm_pkg.sv | 39 +++
 rtl/atm_account_lookup.sv | 22 ++
 rtl/atm_machine.sv | 138 +++++++++++++
 tb/tb_atm_machine.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/atm_pkg.sv
// atm_pkg: shared types and constants for the ATM controller.
//   state_t     - controller state codes (menuOption uses the same encoding)
//   lookup_t    - account-table search result {hit, idx}
//   ACC_NUMS    - fixed account numbers, index 0..NUM_ACCOUNTS-1
//   ACC_PINS    - PIN for each account, same indexing
package atm_pkg;

  localparam int NUM_ACCOUNTS = 10;
  localparam int AW = 12;  // account number width
  localparam int PW = 4;   // PIN width
  localparam int BW = 11;  // balance / amount width
  localparam int IW = 4;   // account index width

  typedef enum logic [2:0] {
    WAITING               = 3'd0,
    GET_PIN               = 3'd1,
    MENU                  = 3'd2,
    BALANCE               = 3'd3,
    WITHDRAW              = 3'd4,
    WITHDRAW_SHOW_BALANCE = 3'd5,
    TRANSACTION           = 3'd6,
    DONE                  = 3'd7
  } state_t;

  typedef struct packed {
    logic          hit;
    logic [IW-1:0] idx;
  } lookup_t;

  localparam logic [AW-1:0] ACC_NUMS [NUM_ACCOUNTS] = '{
    12'd2749, 12'd2175, 12'd2429, 12'd2502, 12'd2148,
    12'd2199, 12'd2178, 12'd2000, 12'd2816, 12'd2711
  };

  localparam logic [PW-1:0] ACC_PINS [NUM_ACCOUNTS] = '{
    4'd1, 4'd2, 4'd3, 4'd5, 4'd7, 4'd8, 4'd4, 4'd9, 4'd6, 4'd10
  };

endpackage

// File: rtl/atm_account_lookup.sv
// atm_account_lookup: combinational search of the fixed account table.
//   number  in  12  account number to find
//   result  out     {hit, idx}; idx is 0 when no entry matches
module atm_account_lookup
  import atm_pkg::*;
(
  input  logic [AW-1:0] number,
  output lookup_t       result
);

  // Account numbers are unique, so at most one entry can match.
  always_comb begin
    result = '0;
    for (int i = 0; i < NUM_ACCOUNTS; i++) begin
      if (number == ACC_NUMS[i]) begin
        result.hit = 1'b1;
        result.idx = IW'(i);
      end
    end
  end

endmodule

// File: rtl/atm_machine.sv
// atm_machine: single-clock ATM controller over a fixed account table.
//   clk, rst_n            clock, synchronous active-low reset
//   exit                  level; abandons the session, back to WAITING
//   accNumber, pin        login credentials
//   destinationAccNumber  transfer target
//   menuOption            requested operation (state-code encoding)
//   amount                withdrawal / transfer amount
//   error                 registered; high after a rejected action
//   balance               registered balance display
//   clk_out               registered clk/2
module atm_machine
  import atm_pkg::*;
#(
  parameter logic [BW-1:0] INIT_BALANCE = 11'd500
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          exit,
  input  logic [AW-1:0] accNumber,
  input  logic [PW-1:0] pin,
  input  logic [AW-1:0] destinationAccNumber,
  input  logic [2:0]    menuOption,
  input  logic [BW-1:0] amount,
  output logic          error,
  output logic [BW-1:0] balance,
  output logic          clk_out
);

  state_t        state, state_nx;
  logic [IW-1:0] cur_idx, cur_idx_nx;
  logic          error_nx;
  logic [BW-1:0] balance_nx;
  logic [BW-1:0] accts [NUM_ACCOUNTS];

  lookup_t       login, dst;
  logic [BW-1:0] own_bal, own_val, dst_val;
  logic [BW:0]   dst_sum;
  logic          wr_own, wr_dst;

  atm_account_lookup u_login (.number(accNumber),            .result(login));
  atm_account_lookup u_dst   (.number(destinationAccNumber), .result(dst));

  assign own_bal = accts[cur_idx];
  // One extra bit so a destination overflow shows up as a carry.
  assign dst_sum = {1'b0, accts[dst.idx]} + {1'b0, amount};

  always_comb begin
    state_nx   = state;
    cur_idx_nx = cur_idx;
    error_nx   = error;
    balance_nx = balance;
    wr_own     = 1'b0;
    wr_dst     = 1'b0;
    own_val    = own_bal - amount;
    dst_val    = dst_sum[BW-1:0];
    if (exit) begin
      state_nx   = WAITING;
      error_nx   = 1'b0;
      balance_nx = '0;
    end else begin
      unique case (state)
        WAITING: begin
          if (login.hit) begin
            cur_idx_nx = login.idx;
            state_nx   = GET_PIN;
            error_nx   = 1'b0;
          end else begin
            error_nx   = 1'b1;
          end
        end
        GET_PIN: begin
          if (pin == ACC_PINS[cur_idx]) begin
            state_nx = MENU;
            error_nx = 1'b0;
          end else begin
            state_nx = WAITING;
            error_nx = 1'b1;
          end
        end
        MENU: begin
          // Options 0..2 are not operations; stay put with outputs held.
          if (menuOption >= 3'd3) state_nx = state_t'(menuOption);
        end
        BALANCE: begin
          balance_nx = own_bal;
          error_nx   = 1'b0;
          state_nx   = MENU;
        end
        WITHDRAW, WITHDRAW_SHOW_BALANCE: begin
          state_nx = MENU;
          if (amount > own_bal) begin
            error_nx = 1'b1;
          end else begin
            wr_own   = 1'b1;
            error_nx = 1'b0;
            if (state == WITHDRAW_SHOW_BALANCE) balance_nx = own_val;
          end
        end
        TRANSACTION: begin
          state_nx = MENU;
          if (!dst.hit || dst.idx == cur_idx || amount > own_bal || dst_sum[BW]) begin
            error_nx = 1'b1;
          end else begin
            wr_own   = 1'b1;
            wr_dst   = 1'b1;
            error_nx = 1'b0;
          end
        end
        DONE: begin
          state_nx   = WAITING;
          error_nx   = 1'b0;
          balance_nx = '0;
        end
        default: state_nx = WAITING;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= WAITING;
      cur_idx <= '0;
      error   <= 1'b0;
      balance <= '0;
      clk_out <= 1'b0;
      for (int i = 0; i < NUM_ACCOUNTS; i++) accts[i] <= INIT_BALANCE;
    end else begin
      state   <= state_nx;
      cur_idx <= cur_idx_nx;
      error   <= error_nx;
      balance <= balance_nx;
      clk_out <= ~clk_out;
      if (wr_own) accts[cur_idx] <= own_val;
      if (wr_dst) accts[dst.idx] <= dst_val;
    end
  end

endmodule

// File: tb/tb_atm_machine.sv
// tb_atm_machine: directed self-checking bench for atm_machine.
module tb_atm_machine;

  logic        clk = 1'b0;
  logic        rst_n, exit;
  logic [11:0] accNumber, destinationAccNumber;
  logic [3:0]  pin;
  logic [2:0]  menuOption;
  logic [10:0] amount;
  logic        error, clk_out;
  logic [10:0] balance;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  atm_machine dut (
    .clk(clk), .rst_n(rst_n), .exit(exit), .accNumber(accNumber), .pin(pin),
    .destinationAccNumber(destinationAccNumber), .menuOption(menuOption),
    .amount(amount), .error(error), .balance(balance), .clk_out(clk_out)
  );

  // Inputs change 1 time unit after the edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic login(input logic [11:0] acc, input logic [3:0] p);
    exit = 1'b1; tick(); exit = 1'b0;
    accNumber = acc; tick();
    pin = p; tick();
  endtask

  task automatic do_op(input logic [2:0] opt);
    menuOption = opt; tick(); tick();
    menuOption = 3'd0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tick();
    checks++; if (dut.state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", dut.state); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error got %b want 0", error); end
    checks++; if (balance !== 11'd0) begin errors++; $display("FAIL reset_balance got %0d want 0", balance); end
    checks++; if (clk_out !== 1'b0) begin errors++; $display("FAIL reset_clk_out got %b want 0", clk_out); end
    rst_n = 1'b1;
  endtask

  task automatic test_login();
    accNumber = 12'd2278; tick();
    checks++; if (error !== 1'b1 || dut.state !== 3'd0) begin errors++; $display("FAIL bad_acc err=%b state=%0d want 1/0", error, dut.state); end
    accNumber = 12'd2178; tick();
    checks++; if (error !== 1'b0 || dut.state !== 3'd1) begin errors++; $display("FAIL good_acc err=%b state=%0d want 0/1", error, dut.state); end
    pin = 4'd4; tick();
    checks++; if (error !== 1'b0 || dut.state !== 3'd2) begin errors++; $display("FAIL good_pin err=%b state=%0d want 0/2", error, dut.state); end
  endtask

  task automatic test_withdraw();
    menuOption = 3'd5; amount = 11'd100; tick();
    checks++; if (dut.state !== 3'd5) begin errors++; $display("FAIL wsb_enter state=%0d want 5", dut.state); end
    tick(); menuOption = 3'd0;
    checks++; if (balance !== 11'd400 || error !== 1'b0 || dut.state !== 3'd2) begin errors++; $display("FAIL wsb bal=%0d err=%b state=%0d want 400/0/2", balance, error, dut.state); end
    do_op(3'd3);
    checks++; if (balance !== 11'd400) begin errors++; $display("FAIL bal_after_wsb got %0d want 400", balance); end
    tick();
    checks++; if (dut.state !== 3'd2 || balance !== 11'd400) begin errors++; $display("FAIL menu_idle state=%0d bal=%0d want 2/400", dut.state, balance); end
    amount = 11'd452; do_op(3'd4);
    checks++; if (error !== 1'b1 || balance !== 11'd400) begin errors++; $display("FAIL overdraw err=%b bal=%0d want 1/400", error, balance); end
    do_op(3'd3);
    checks++; if (error !== 1'b0 || balance !== 11'd400) begin errors++; $display("FAIL overdraw_bal err=%b bal=%0d want 0/400", error, balance); end
  endtask

  task automatic test_transfer();
    destinationAccNumber = 12'd2816; amount = 11'd50; do_op(3'd6);
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL xfer_ok err=%b want 0", error); end
    do_op(3'd3);
    checks++; if (balance !== 11'd350) begin errors++; $display("FAIL xfer_own got %0d want 350", balance); end
    amount = 11'd502; do_op(3'd6);
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL xfer_insuff err=%b want 1", error); end
    destinationAccNumber = 12'd9999; amount = 11'd10; do_op(3'd6);
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL xfer_unknown err=%b want 1", error); end
    destinationAccNumber = 12'd2178; do_op(3'd6);
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL xfer_self err=%b want 1", error); end
    do_op(3'd3);
    checks++; if (balance !== 11'd350) begin errors++; $display("FAIL xfer_reject_bal got %0d want 350", balance); end
    exit = 1'b1; tick();
    checks++; if (dut.state !== 3'd0 || error !== 1'b0 || balance !== 11'd0) begin errors++; $display("FAIL exit state=%0d err=%b bal=%0d want 0/0/0", dut.state, error, balance); end
    tick();
    checks++; if (dut.state !== 3'd0) begin errors++; $display("FAIL exit_held state=%0d want 0", dut.state); end
    exit = 1'b0;
    login(12'd2816, 4'd6); do_op(3'd3);
    checks++; if (balance !== 11'd550) begin errors++; $display("FAIL dest_bal got %0d want 550", balance); end
  endtask

  task automatic test_wrong_pin();
    exit = 1'b1; tick(); exit = 1'b0;
    accNumber = 12'd2178; tick();
    pin = 4'd5; tick();
    checks++; if (error !== 1'b1 || dut.state !== 3'd0) begin errors++; $display("FAIL wrong_pin err=%b state=%0d want 1/0", error, dut.state); end
  endtask

  task automatic test_overflow();
    // Pile three full accounts into 2000 (500 -> 2000).
    destinationAccNumber = 12'd2000; amount = 11'd500;
    login(12'd2749, 4'd1); do_op(3'd6);
    login(12'd2175, 4'd2); do_op(3'd6);
    login(12'd2429, 4'd3); do_op(3'd6);
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL fill_dest err=%b want 0", error); end
    login(12'd2502, 4'd5);
    amount = 11'd48; do_op(3'd6);
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL dest_overflow err=%b want 1", error); end
    do_op(3'd3);
    checks++; if (balance !== 11'd500) begin errors++; $display("FAIL overflow_own got %0d want 500", balance); end
    amount = 11'd47; do_op(3'd6);
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL dest_max err=%b want 0", error); end
    login(12'd2000, 4'd9);
    amount = 11'd0; do_op(3'd5);
    checks++; if (balance !== 11'd2047 || error !== 1'b0) begin errors++; $display("FAIL zero_wd bal=%0d err=%b want 2047/0", balance, error); end
  endtask

  task automatic test_done();
    menuOption = 3'd7; tick(); menuOption = 3'd0;
    checks++; if (dut.state !== 3'd7) begin errors++; $display("FAIL done_enter state=%0d want 7", dut.state); end
    tick();
    checks++; if (dut.state !== 3'd0 || error !== 1'b0 || balance !== 11'd0) begin errors++; $display("FAIL done_exit state=%0d err=%b bal=%0d want 0/0/0", dut.state, error, balance); end
  endtask

  task automatic test_reset_mid();
    login(12'd2000, 4'd9);
    menuOption = 3'd5; amount = 11'd10; tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1; menuOption = 3'd0;
    checks++; if (dut.state !== 3'd0 || error !== 1'b0 || balance !== 11'd0 || clk_out !== 1'b0) begin errors++; $display("FAIL mid_reset state=%0d err=%b bal=%0d clk_out=%b want 0/0/0/0", dut.state, error, balance, clk_out); end
    accNumber = 12'd0; tick();
    checks++; if (clk_out !== 1'b1) begin errors++; $display("FAIL clk_out_1 got %b want 1", clk_out); end
    tick();
    checks++; if (clk_out !== 1'b0) begin errors++; $display("FAIL clk_out_2 got %b want 0", clk_out); end
    login(12'd2000, 4'd9); do_op(3'd3);
    checks++; if (balance !== 11'd500) begin errors++; $display("FAIL rst_bal_2000 got %0d want 500", balance); end
    login(12'd2178, 4'd4); do_op(3'd3);
    checks++; if (balance !== 11'd500) begin errors++; $display("FAIL rst_bal_2178 got %0d want 500", balance); end
  endtask

  initial begin
    rst_n = 1'b0; exit = 1'b0; accNumber = '0; pin = '0;
    destinationAccNumber = '0; menuOption = '0; amount = '0;
    #2;
    test_reset();
    test_login();
    test_withdraw();
    test_transfer();
    test_wrong_pin();
    test_overflow();
    test_done();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
